receptor_serial: RTL and testbench
==================================

# receptor_serial

Serial-to-parallel receiver that rebuilds a `size`-bit word from a bit stream produced by the team's universal shift register in shift mode. It collects `size` strobed bits, MSB-first or LSB-first, and presents the word on a valid/ready handshake to the downstream consumer. It sits at the receive end of the serial link between shift-register transmitters and parallel datapath logic.

## Interface
- `size`, default 8: word width; must be ≥ 2.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that opens a frame and latches `dir`.
- `dir`, in, 1: bit order. 1 means LSB-first: shift right, new bit enters bit `size-1`. 0 means MSB-first: shift left, new bit enters bit 0.
- `din`, in, 1: serial data bit.
- `din_valid`, in, 1: `din` is sampled on this edge.
- `ready`, in, 1: consumer accepts `Y`.
- `Y`, out, `size`: last completed word.
- `valid`, out, 1: `Y` holds an unconsumed word.
- `busy`, out, 1: a frame is being received.
- `overrun`, out, 1: sticky; a bit arrived while a word was still pending.

## Operation
- The FSM has three states:
  - `IDLE`: leaves on `start`; moves to `RECV`, clears bit counter and shift register, latches `dir`.
  - `RECV`: each `din_valid` shifts `din` in and increments the counter. On the `din_valid` that carries bit number `size-1`, the full word is copied to `Y`, `valid` is set, and the FSM moves to `HOLD`.
  - `HOLD`: while `valid` && `ready`, clears `valid` and returns to `IDLE`. If `start` arrives in the same cycle as the handshake, the FSM goes directly to `RECV`.
- `dir` is ignored outside the cycle in which `start` is accepted.
- `start` during `RECV` restarts the frame. Counter and shift register are cleared, partial bits are discarded, and `Y` is unchanged.
- `start` during `HOLD` without `ready` is ignored.
- `din_valid` in `IDLE` is ignored.
- `din_valid` in `HOLD` discards the bit and sets `overrun`. `overrun` clears only on reset.
- `Y` changes only at word completion; the partial word is never visible.
- `busy` = 1 exactly in `RECV`.
- Counter width is `$clog2(size)`. It never wraps inside a frame, because the state changes at count `size-1`.
- Reset values: FSM = `IDLE`, `Y` = 0, `valid` = 0, `busy` = 0, `overrun` = 0. The internal shift register and counter are also 0.
- Reset asserted mid-frame or mid-hold drops all state immediately, asynchronously.

## Timing
- `busy` rises the cycle after the `start` edge.
- Minimum frame time is `size` cycles of `din_valid` after `start`, with one bit per clock at most. Gaps in `din_valid` stretch the frame with no limit.
- `Y` and `valid` update on the same edge that samples the last bit. Latency from last bit to `valid` is 0 cycles: it is visible right after that edge.
- `valid` holds, and `Y` is stable, until the edge where `ready` = 1. `valid` falls after that edge.
- `ready` is don't-care while `valid` = 0.
- If `ready` is high permanently, a new `start` is accepted in the cycle of the handshake. Back-to-back throughput is therefore `size` + 1 cycles per word, counting the `start` cycle.

## Structure
- A shared package holds the state enum (`IDLE`, `RECV`, `HOLD`) and a counter-width helper (`$clog2(size)`).
- One sub-module, `registrador_entrada_serial`, is the natural split. It is a `size`-bit shift register with `clr`, `shift_en`, `dir` and serial-in, and it outputs its parallel contents.
- The top level holds the FSM, the counter, the output register `Y`, and the flags.

## Test plan
All scenarios use `size` = 8.
- **MSB-first.** `start` with `dir` = 0, then bits 1,0,1,0,0,1,0,1 on consecutive cycles, `ready` = 1 → `Y` = 0xA5 and `valid` high for one cycle, on the 8th sampling edge.
- **LSB-first.** `start` with `dir` = 1, then bits 1,0,1,0,0,1,0,1 → `Y` = 0xA5. Then a frame of bits 1,1,1,1,0,0,0,0 → `Y` = 0x0F.
- **Gapped input and backpressure.** 0x3C sent MSB-first with idle cycles between `din_valid` pulses, `ready` = 0 → `valid` stays high with `Y` = 0x3C until `ready` = 1, then falls. A `din_valid` during `HOLD` → `overrun` = 1 and `Y` stays 0x3C.
- **Restart.** `start` after 5 bits of 0xFF, then a full MSB-first frame of 0x81 → `Y` = 0x81 and no intermediate `valid`.
- **Reset mid-frame.** `rst_n` low after 3 bits → all outputs 0 asynchronously. After release, a clean frame of 0x5A → `Y` = 0x5A.
- **Back-to-back.** Two frames, 0x12 then 0x34, with `start` in the handshake cycle → both words delivered in order with no lost bits.

Source files
------------

// File: rtl/receptor_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : receptor_serial_pkg
// Purpose  : Shared state encoding and counter sizing for receptor_serial.
// Revision : 1.0 - initial release
// ============================================================================
package receptor_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Bit-counter width; a word of at least two bits keeps this non-zero.
  function automatic int cnt_width(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/registrador_entrada_serial.sv
`default_nettype none
// ============================================================================
// Module   : registrador_entrada_serial
// Purpose  : size-bit serial-in shift register with clear and bit-order select.
// Revision : 1.0 - initial release
// ============================================================================
module registrador_entrada_serial #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            shift_en,
  input  logic            dir,
  input  logic            sin,
  output logic [size-1:0] q_next
);

  logic [size-1:0] r_q;
  logic [size-1:0] w_shifted;

  // dir=1: LSB-first, new bit enters the top; dir=0: MSB-first, enters bit 0.
  always_comb begin
    w_shifted = dir ? {sin, r_q[size-1:1]} : {r_q[size-2:0], sin};
  end

  // q_next exposes the contents after this edge so a completed word can be
  // captured on the same edge that samples its last bit.
  always_comb begin
    q_next = r_q;
    if (clr) begin
      q_next = '0;
    end else if (shift_en) begin
      q_next = w_shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= q_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/receptor_serial.sv
`default_nettype none
// ============================================================================
// Module   : receptor_serial
// Purpose  : Serial-to-parallel receiver presenting words on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module receptor_serial
  import receptor_serial_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dir,
  input  logic            din,
  input  logic            din_valid,
  input  logic            ready,
  output logic [size-1:0] Y,
  output logic            valid,
  output logic            busy,
  output logic            overrun
);

  localparam int                 c_CNT_W = cnt_width(size);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(size - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dir;
  logic [size-1:0]    r_y;
  logic               r_valid;
  logic               r_overrun;
  logic [size-1:0]    w_word;
  logic               w_clr;
  logic               w_shift;
  logic               w_load;
  logic               w_consume;
  logic               w_ovr;

  registrador_entrada_serial #(
    .size(size)
  ) u_sreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_clr),
    .shift_en (w_shift),
    .dir      (r_dir),
    .sin      (din),
    .q_next   (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_consume   = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RECV;
          w_clr       = 1'b1;
        end
      end
      RECV: begin
        // A restart wins over a bit arriving in the same cycle.
        if (start) begin
          w_clr = 1'b1;
        end else if (din_valid) begin
          w_shift = 1'b1;
          if (r_cnt == c_LAST) begin
            w_load      = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        w_ovr = din_valid;
        if (r_valid && ready) begin
          w_consume = 1'b1;
          if (start) begin
            w_state_nxt = RECV;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_y       <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_clr) begin
        r_cnt <= '0;
        r_dir <= dir;
      end else if (w_load) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_load) begin
        r_y     <= w_word;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (w_ovr) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign Y       = r_y;
  assign valid   = r_valid;
  assign busy    = (r_state == RECV);
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_receptor_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_receptor_serial
// Purpose  : Scoreboard bench for receptor_serial with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receptor_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] Y;
  logic       valid;
  logic       busy;
  logic       overrun;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  receptor_serial #(.size(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .din       (din),
    .din_valid (din_valid),
    .ready     (ready),
    .Y         (Y),
    .valid     (valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts n bits of word in the order selected by d; no start pulse.
  task automatic send_bits(input logic [7:0] word, input logic d, input int n,
                           input int gap, input bit push);
    for (int i = 0; i < n; i++) begin
      din       = d ? word[i] : word[7-i];
      din_valid = 1'b1;
      if (push && i == 7) exp_q.push_back(word);
      tick();
      din_valid = 1'b0;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] word, input logic d, input int gap);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
    dir   = ~d;
    send_bits(word, d, 8, gap, 1'b1);
  endtask

  // Monitor: a word appearing or being consumed must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got Y=0x%0h expected no word @%0t", Y, $time);
        end else begin
          check("word_on_valid", {24'd0, Y}, {24'd0, exp_q[0]});
        end
      end
      if (valid && ready && exp_q.size() != 0) begin
        check("word_at_handshake", {24'd0, Y}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_valid = valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("reset_Y", {24'd0, Y}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();

    // MSB-first 0xA5 with ready high: one-cycle valid
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    send_bits(8'hA5, 1'b0, 8, 0, 1'b1);
    check("msb_valid_high", {31'd0, valid}, 32'd1);
    check("msb_Y", {24'd0, Y}, 32'h0000_00A5);
    check("msb_busy_low", {31'd0, busy}, 32'd0);
    tick();
    check("msb_valid_one_cycle", {31'd0, valid}, 32'd0);

    // LSB-first 0xA5 then 0x0F
    send_frame(8'hA5, 1'b1, 0);
    check("lsb_Y_a5", {24'd0, Y}, 32'h0000_00A5);
    tick();
    send_frame(8'h0F, 1'b1, 0);
    check("lsb_Y_0f", {24'd0, Y}, 32'h0000_000F);
    repeat (2) tick();

    // Gapped 0x3C with backpressure and overrun
    ready = 1'b0;
    send_frame(8'h3C, 1'b0, 2);
    repeat (3) tick();
    check("bp_valid_held", {31'd0, valid}, 32'd1);
    check("bp_Y_held", {24'd0, Y}, 32'h0000_003C);
    check("overrun_before", {31'd0, overrun}, 32'd0);
    din = 1'b1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_Y_kept", {24'd0, Y}, 32'h0000_003C);
    check("overrun_valid_kept", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    tick();
    check("bp_valid_fall", {31'd0, valid}, 32'd0);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    tick();

    // Restart after 5 bits of 0xFF, then 0x81
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    send_bits(8'hFF, 1'b0, 5, 0, 1'b0);
    check("restart_no_valid", {31'd0, valid}, 32'd0);
    send_frame(8'h81, 1'b0, 0);
    check("restart_Y", {24'd0, Y}, 32'h0000_0081);
    repeat (2) tick();

    // Asynchronous reset mid-frame
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    send_bits(8'hFF, 1'b0, 3, 0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async_Y", {24'd0, Y}, 32'd0);
    check("async_valid", {31'd0, valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_overrun", {31'd0, overrun}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h5A, 1'b0, 0);
    check("post_reset_Y", {24'd0, Y}, 32'h0000_005A);
    repeat (2) tick();

    // Back-to-back frames, start in the handshake cycle
    send_frame(8'h12, 1'b0, 0);
    send_frame(8'h34, 1'b0, 0);
    check("b2b_Y_second", {24'd0, Y}, 32'h0000_0034);
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
